// File: rtl/axi_width_upsizer.sv
// AXI-stream width upsizer: packs p_ratio narrow beats into one wide word.
// A last flag flushes a partial word early, and the keep mask marks the filled lanes.
module axi_width_upsizer #(
   parameter int p_width = 8,
   parameter int p_ratio = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [p_width-1:0]         i_data_in,
   input  logic                       i_valid_in,
   input  logic                       i_last_in,
   output logic                       o_ready_in,
   output logic [p_width*p_ratio-1:0] o_data_out,
   output logic [p_ratio-1:0]         o_keep,
   output logic                       o_last_out,
   output logic                       o_valid_out,
   input  logic                       i_ready_out
);

   localparam int                 cnt_w     = (p_ratio > 1) ? $clog2(p_ratio) : 1;
   localparam logic [cnt_w-1:0]   last_lane = cnt_w'(p_ratio - 1);

   typedef enum logic {s_acc, s_out} state_t;

   state_t                       state;
   logic                         run;
   logic [cnt_w-1:0]             cnt;
   logic [p_width*p_ratio-1:0]   acc;
   logic [p_width*p_ratio-1:0]   word_next;
   logic [p_ratio-1:0]           keep_next;
   logic                         accept_in;
   logic                         accept_out;
   logic                         complete;

   // run holds ready low through reset and rises on the first edge after release
   assign o_ready_in = run & (~o_valid_out | i_ready_out);
   assign accept_in  = i_valid_in & o_ready_in;
   assign accept_out = o_valid_out & i_ready_out;
   assign complete   = accept_in & (i_last_in | (cnt == last_lane));

   // NOTE: every variable gets a default before the loop, so no latch is inferred.
   always_comb begin
      word_next = acc;
      keep_next = '0;
      for (int k = 0; k < p_ratio; k++) begin
         if (cnt_w'(k) == cnt) word_next[k*p_width +: p_width] = i_data_in;
         if (cnt_w'(k) <= cnt) keep_next[k] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= s_acc;
         run         <= 1'b0;
         cnt         <= '0;
         acc         <= '0;
         o_data_out  <= '0;
         o_keep      <= '0;
         o_last_out  <= 1'b0;
         o_valid_out <= 1'b0;
      end else begin
         run <= 1'b1;

         if (accept_in) begin
            if (complete) begin
               cnt <= '0;
               acc <= '0;
            end else begin
               cnt <= cnt + 1'b1;
               acc <= word_next;
            end
         end

         // Lanes above cnt are already zero in acc because it is cleared on every completion
         case (state)
            s_acc: begin
               if (complete) begin
                  o_data_out  <= word_next;
                  o_keep      <= keep_next;
                  o_last_out  <= i_last_in;
                  o_valid_out <= 1'b1;
                  state       <= s_out;
               end
            end
            s_out: begin
               if (complete) begin
                  o_data_out  <= word_next;
                  o_keep      <= keep_next;
                  o_last_out  <= i_last_in;
                  o_valid_out <= 1'b1;
               end else if (accept_out) begin
                  o_valid_out <= 1'b0;
                  state       <= s_acc;
               end
            end
            default: begin
               o_valid_out <= 1'b0;
               state       <= s_acc;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_width_upsizer.sv
// Scoreboard bench for axi_width_upsizer: the driver queues expected words,
// and the monitor compares each presented word against the head of the queue.
module tb_axi_width_upsizer;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [7:0]  i_data_in;
   logic        i_valid_in;
   logic        i_last_in;
   logic        o_ready_in;
   logic [31:0] o_data_out;
   logic [3:0]  o_keep;
   logic        o_last_out;
   logic        o_valid_out;
   logic        i_ready_out;

   word_t       exp_q[$];
   int          n_checks    = 0;
   int          n_pass      = 0;
   int          cyc         = 0;
   int          total_bytes = 0;
   logic [3:0]  kp1;

   axi_width_upsizer #(.p_width(8), .p_ratio(4)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_data_in   (i_data_in),
      .i_valid_in  (i_valid_in),
      .i_last_in   (i_last_in),
      .o_ready_in  (o_ready_in),
      .o_data_out  (o_data_out),
      .o_keep      (o_keep),
      .o_last_out  (o_last_out),
      .o_valid_out (o_valid_out),
      .i_ready_out (i_ready_out)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_q.push_back('{data: d, keep: k, last: l});
   endtask

   // Present one beat and hold it until accepted; returns at posedge+1 of the accept
   task automatic send(input logic [7:0] d, input logic l, output int waits);
      waits      = 0;
      i_data_in  = d;
      i_last_in  = l;
      i_valid_in = 1'b1;
      @(negedge i_clk);
      while (!o_ready_in && waits < 200) begin
         waits++;
         @(negedge i_clk);
      end
      if (!o_ready_in) begin
         n_checks++;
         $display("FAIL send_timeout: beat %0h never accepted", d);
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_valid_in = 1'b0;
      i_last_in  = 1'b0;
   endtask

   // Monitor: compare every cycle a word is presented, pop when it is accepted
   always @(negedge i_clk) begin
      if (i_reset && o_valid_out) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_word: got data=%h keep=%b, expected no word", o_data_out, o_keep);
         end else begin
            check("out_data", o_data_out, exp_q[0].data);
            check("out_keep", o_keep, exp_q[0].keep);
            check("out_last", o_last_out, exp_q[0].last);
            kp1 = o_keep + 4'd1;
            check("keep_contiguous", kp1 & o_keep, 0);
            if (i_ready_out) begin
               total_bytes += $countones(o_keep);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          w;
      int          t0;
      int          n;
      int          bytes_before;
      bit          done;
      logic [31:0] acc;
      logic [3:0]  kk;
      int          m;
      logic [7:0]  b;
      logic        l;
      logic [7:0]  full_tail[4];

      i_reset = 1'b0; i_data_in = '0; i_valid_in = 1'b0; i_last_in = 1'b0; i_ready_out = 1'b1;

      // Reset state
      #12;
      check("rst_valid", o_valid_out, 0);
      check("rst_data", o_data_out, 0);
      check("rst_keep", o_keep, 0);
      check("rst_last", o_last_out, 0);
      check("rst_ready", o_ready_in, 0);
      #20 i_reset = 1'b1;
      @(posedge i_clk); #1;
      check("ready_after_release", o_ready_in, 1);

      // Full words, continuous beats
      push(32'h44332211, 4'hF, 1'b0);
      push(32'h88776655, 4'hF, 1'b0);
      send(8'h11, 0, w); send(8'h22, 0, w); send(8'h33, 0, w); send(8'h44, 0, w);
      check("lat_valid", o_valid_out, 1);
      check("lat_data", o_data_out, 32'h44332211);
      t0 = cyc;
      full_tail = '{8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 4; i++) begin
         send(full_tail[i], 0, w);
         check("full_no_stall", w, 0);
      end
      check("word2_spacing", cyc - t0, 4);
      check("word2_valid", o_valid_out, 1);
      check("word2_data", o_data_out, 32'h88776655);
      idle(); @(posedge i_clk); #1;

      // Partial flush, then restart at lane 0 with a last on lane 3
      push(32'h0000B2A1, 4'b0011, 1'b1);
      send(8'hA1, 0, w); send(8'hB2, 1, w);
      check("flush_data", o_data_out, 32'h0000B2A1);
      push(32'hD4D3D2D1, 4'hF, 1'b1);
      send(8'hD1, 0, w); send(8'hD2, 0, w); send(8'hD3, 0, w); send(8'hD4, 1, w);
      check("last_lane3_data", o_data_out, 32'hD4D3D2D1);
      check("last_lane3_last", o_last_out, 1);
      idle(); @(posedge i_clk); #1;

      // Backpressure: word held, upstream beat 0x99 stalls until one ready cycle
      i_ready_out = 1'b0;
      push(32'hE4E3E2E1, 4'hF, 1'b0);
      send(8'hE1, 0, w); send(8'hE2, 0, w); send(8'hE3, 0, w); send(8'hE4, 0, w);
      idle();
      repeat (2) begin
         @(negedge i_clk);
         check("bp_ready_low", o_ready_in, 0);
         check("bp_valid_high", o_valid_out, 1);
      end
      @(posedge i_clk); #1;
      push(32'h00000099, 4'b0001, 1'b1);
      i_data_in = 8'h99; i_last_in = 1'b1; i_valid_in = 1'b1;
      @(negedge i_clk);
      check("bp_beat_held", o_ready_in, 0);
      @(posedge i_clk); #1;
      i_ready_out = 1'b1;
      @(negedge i_clk);
      check("bp_release_ready", o_ready_in, 1);
      @(posedge i_clk); #1;
      idle(); i_ready_out = 1'b0;
      check("bp_new_valid", o_valid_out, 1);
      check("bp_lane0_data", o_data_out, 32'h00000099);
      check("bp_lane0_keep", o_keep, 4'b0001);
      @(posedge i_clk); #1; i_ready_out = 1'b1;
      @(posedge i_clk); #1;

      // Back-to-back: completions coincide with output accepts
      push(32'hC4C3C2C1, 4'hF, 1'b0);
      push(32'h000000C5, 4'b0001, 1'b1);
      push(32'h000000C6, 4'b0001, 1'b1);
      push(32'h0000C8C7, 4'b0011, 1'b1);
      send(8'hC1, 0, w); send(8'hC2, 0, w); send(8'hC3, 0, w); send(8'hC4, 0, w);
      send(8'hC5, 1, w);
      check("b2b_valid_c5", o_valid_out, 1);
      check("b2b_data_c5", o_data_out, 32'h000000C5);
      send(8'hC6, 1, w);
      check("b2b_valid_c6", o_valid_out, 1);
      check("b2b_data_c6", o_data_out, 32'h000000C6);
      send(8'hC7, 0, w); send(8'hC8, 1, w);
      idle(); @(posedge i_clk); #1; @(posedge i_clk); #1;

      // Asynchronous reset mid-packet discards the partial word
      send(8'hF1, 0, w); send(8'hF2, 0, w); send(8'hF3, 0, w);
      idle();
      #3 i_reset = 1'b0;
      #1;
      check("mid_rst_data", o_data_out, 0);
      check("mid_rst_keep", o_keep, 0);
      check("mid_rst_last", o_last_out, 0);
      check("mid_rst_valid", o_valid_out, 0);
      check("mid_rst_ready", o_ready_in, 0);
      @(posedge i_clk); @(posedge i_clk); #2 i_reset = 1'b1;
      @(posedge i_clk); #1;
      check("mid_rst_ready_after", o_ready_in, 1);
      push(32'h04030201, 4'hF, 1'b0);
      send(8'h01, 0, w); send(8'h02, 0, w); send(8'h03, 0, w); send(8'h04, 0, w);
      check("post_rst_data", o_data_out, 32'h04030201);
      idle(); @(posedge i_clk); #1;

      // Stress: bursty upstream, random downstream ready, random last flags
      bytes_before = total_bytes;
      done = 1'b0;
      acc  = '0;
      m    = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               idle();
               repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
               b = 8'($urandom_range(0, 255));
               l = (i == 999) || ($urandom_range(0, 7) == 0);
               acc[8*m +: 8] = b;
               m++;
               if (l || m == 4) begin
                  kk = '0;
                  for (int j = 0; j < m; j++) kk[j] = 1'b1;
                  push(acc, kk, l);
                  acc = '0;
                  m   = 0;
               end
               send(b, l, w);
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge i_clk); #1;
               i_ready_out = ($urandom_range(0, 3) != 0);
            end
            i_ready_out = 1'b1;
         end
      join
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge i_clk);
         n++;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
      check("stress_bytes", total_bytes - bytes_before, 1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
